cpu_control_fsm: RTL and testbench

Multi-cycle control unit that sequences the 33-bit-instruction CPU datapath: it fetches from instruction memory, holds the instruction register feeding `decode_instruction`, and steps each opcode through execute, memory and writeback. It drives the register-file write enable, the data-memory handshake, the compare flag and the program counter. It sits between the instruction/data memory ports and the decoder, ALU and register file.

---
 rtl/cpu_control_fsm_pkg.sv | 70 +++++++
 rtl/cpu_control_fsm_pc_unit.sv | 37 +++
 rtl/cpu_control_fsm.sv | 132 +++++++++++++
 tb/tb_cpu_control_fsm.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_control_fsm_pkg.sv
// Shared constants, state encoding and opcode classification for the CPU control unit.
package cpu_control_fsm_pkg;

    localparam int unsigned CPU_INSTRUCTION_WIDTH = 33;
    localparam int unsigned CPU_WIDTH_OPCODE      = 5;
    localparam int unsigned CPU_IMMEDIATE_WIDTH   = 16;
    localparam int unsigned CPU_ADDR_WIDTH        = 16;

    localparam int unsigned INSTR_NOP  = 0;
    localparam int unsigned INSTR_LR   = 1;
    localparam int unsigned INSTR_LI   = 2;
    localparam int unsigned INSTR_SR   = 3;
    localparam int unsigned INSTR_MOVE = 4;
    localparam int unsigned INSTR_ADD  = 5;
    localparam int unsigned INSTR_ADDI = 6;
    localparam int unsigned INSTR_SUB  = 7;
    localparam int unsigned INSTR_CMP  = 8;
    localparam int unsigned INSTR_AND  = 9;
    localparam int unsigned INSTR_OR   = 10;
    localparam int unsigned INSTR_NOT  = 11;
    localparam int unsigned INSTR_SHL  = 12;
    localparam int unsigned INSTR_SHR  = 13;
    localparam int unsigned INSTR_BNE  = 14;
    localparam int unsigned INSTR_BE   = 15;
    localparam int unsigned INSTR_HALT = 31;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_IMM = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_e;

    // What EXECUTE does with an opcode; OPC_SEQ covers NOP and undefined opcodes.
    typedef enum logic [2:0] {
        OPC_WB   = 3'd0,
        OPC_MEM  = 3'd1,
        OPC_CMP  = 3'd2,
        OPC_BE   = 3'd3,
        OPC_BNE  = 3'd4,
        OPC_HALT = 3'd5,
        OPC_SEQ  = 3'd6
    } op_class_e;

    function automatic op_class_e op_class(input logic [CPU_WIDTH_OPCODE-1:0] op);
        op_class_e cls;
        cls = OPC_SEQ;
        case (op)
            CPU_WIDTH_OPCODE'(INSTR_LI),  CPU_WIDTH_OPCODE'(INSTR_MOVE),
            CPU_WIDTH_OPCODE'(INSTR_ADD), CPU_WIDTH_OPCODE'(INSTR_ADDI),
            CPU_WIDTH_OPCODE'(INSTR_SUB), CPU_WIDTH_OPCODE'(INSTR_AND),
            CPU_WIDTH_OPCODE'(INSTR_OR),  CPU_WIDTH_OPCODE'(INSTR_NOT),
            CPU_WIDTH_OPCODE'(INSTR_SHL), CPU_WIDTH_OPCODE'(INSTR_SHR): cls = OPC_WB;
            CPU_WIDTH_OPCODE'(INSTR_LR),  CPU_WIDTH_OPCODE'(INSTR_SR):  cls = OPC_MEM;
            CPU_WIDTH_OPCODE'(INSTR_CMP):  cls = OPC_CMP;
            CPU_WIDTH_OPCODE'(INSTR_BE):   cls = OPC_BE;
            CPU_WIDTH_OPCODE'(INSTR_BNE):  cls = OPC_BNE;
            CPU_WIDTH_OPCODE'(INSTR_HALT): cls = OPC_HALT;
            default:                       cls = OPC_SEQ;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/cpu_control_fsm_pc_unit.sv
// Program counter: sequential increment or relative branch to pc+1+sext(immediate), modulo 2^ADDR_WIDTH.
module cpu_control_fsm_pc_unit
    import cpu_control_fsm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = CPU_ADDR_WIDTH,
    parameter int unsigned IMMEDIATE_WIDTH = CPU_IMMEDIATE_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_inc,
    input  logic                       i_branch,
    input  logic [IMMEDIATE_WIDTH-1:0] i_immediate,
    output logic [ADDR_WIDTH-1:0]      o_pc
);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_plus1;
    logic [ADDR_WIDTH-1:0] w_imm_sext;
    logic [ADDR_WIDTH-1:0] w_target;

    assign w_pc_plus1 = r_pc + ADDR_WIDTH'(1);
    assign w_imm_sext = ADDR_WIDTH'($signed(i_immediate));
    assign w_target   = w_pc_plus1 + w_imm_sext;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
        end else if (i_branch) begin
            r_pc <= w_target;
        end else if (i_inc) begin
            r_pc <= w_pc_plus1;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit: FETCH/DECODE/EXECUTE/MEM/WB/HALT sequencing of the CPU datapath.
module cpu_control_fsm
    import cpu_control_fsm_pkg::*;
#(
    parameter int unsigned INSTRUCTION_WIDTH = CPU_INSTRUCTION_WIDTH,
    parameter int unsigned WIDTH_OPCODE      = CPU_WIDTH_OPCODE,
    parameter int unsigned IMMEDIATE_WIDTH   = CPU_IMMEDIATE_WIDTH,
    parameter int unsigned ADDR_WIDTH        = CPU_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req,
    output logic [ADDR_WIDTH-1:0]        imem_addr,
    input  logic                         imem_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
    output logic [INSTRUCTION_WIDTH-1:0] ir,
    input  logic [WIDTH_OPCODE-1:0]      opcode,
    input  logic [IMMEDIATE_WIDTH-1:0]   immediate,
    input  logic                         alu_zero,
    output logic [WIDTH_OPCODE-1:0]      alu_op,
    output logic                         dmem_req,
    output logic                         dmem_we,
    input  logic                         dmem_ready,
    output logic                         rf_we,
    output logic [1:0]                   wb_sel,
    output logic                         flag_z,
    output logic [ADDR_WIDTH-1:0]        pc,
    output logic                         halted
);

    state_e                       r_state;
    logic [INSTRUCTION_WIDTH-1:0] r_ir;
    logic                         r_flag_z;

    op_class_e w_class;
    logic      w_is_lr;
    logic      w_is_li;
    logic      w_is_sr;
    logic      w_take_branch;
    logic      w_pc_inc;
    logic      w_pc_branch;

    assign w_class       = op_class(CPU_WIDTH_OPCODE'(opcode));
    assign w_is_lr       = (opcode == WIDTH_OPCODE'(INSTR_LR));
    assign w_is_li       = (opcode == WIDTH_OPCODE'(INSTR_LI));
    assign w_is_sr       = (opcode == WIDTH_OPCODE'(INSTR_SR));
    assign w_take_branch = ((w_class == OPC_BE) && alu_zero) || ((w_class == OPC_BNE) && !alu_zero);

    // pc moves only on the edge leaving EXECUTE, MEM (store) or WB.
    always_comb begin
        w_pc_inc    = 1'b0;
        w_pc_branch = 1'b0;
        case (r_state)
            S_EXECUTE: begin
                if (w_take_branch) begin
                    w_pc_branch = 1'b1;
                end else if ((w_class == OPC_CMP) || (w_class == OPC_BE) ||
                             (w_class == OPC_BNE) || (w_class == OPC_SEQ)) begin
                    w_pc_inc = 1'b1;
                end
            end
            S_MEM:   w_pc_inc = dmem_ready && w_is_sr;
            S_WB:    w_pc_inc = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_ir     <= '0;
            r_flag_z <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= imem_rdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: r_state <= S_EXECUTE;
                S_EXECUTE: begin
                    case (w_class)
                        OPC_WB:   r_state <= S_WB;
                        OPC_MEM:  r_state <= S_MEM;
                        OPC_HALT: r_state <= S_HALT;
                        OPC_CMP: begin
                            r_flag_z <= alu_zero;
                            r_state  <= S_FETCH;
                        end
                        default:  r_state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        r_state <= w_is_lr ? S_WB : S_FETCH;
                    end
                end
                S_WB:    r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    cpu_control_fsm_pc_unit #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .IMMEDIATE_WIDTH (IMMEDIATE_WIDTH)
    ) u_pc_unit (
        .clk         (clk),
        .reset       (reset),
        .i_inc       (w_pc_inc),
        .i_branch    (w_pc_branch),
        .i_immediate (immediate),
        .o_pc        (pc)
    );

    // Strobes decode the current state and are forced low in any reset cycle.
    assign imem_req  = !reset && (r_state == S_FETCH);
    assign dmem_req  = !reset && (r_state == S_MEM);
    assign dmem_we   = dmem_req && w_is_sr;
    assign rf_we     = !reset && (r_state == S_WB);
    assign halted    = !reset && (r_state == S_HALT);
    assign alu_op    = (!reset && (r_state == S_EXECUTE)) ? opcode : '0;
    assign wb_sel    = !rf_we ? WB_SEL_ALU :
                       w_is_lr ? WB_SEL_MEM :
                       w_is_li ? WB_SEL_IMM : WB_SEL_ALU;
    assign imem_addr = pc;
    assign ir        = r_ir;
    assign flag_z    = r_flag_z;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: bench acts as memories and decoder, checks each retired instruction.
module tb_cpu_control_fsm;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [32:0] imem_rdata;
    logic [32:0] ir;
    logic [4:0]  opcode;
    logic [15:0] immediate;
    logic        alu_zero;
    logic [4:0]  alu_op;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        flag_z;
    logic [15:0] pc;
    logic        halted;

    cpu_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .opcode     (opcode),
        .immediate  (immediate),
        .alu_zero   (alu_zero),
        .alu_op     (alu_op),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ready (dmem_ready),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .flag_z     (flag_z),
        .pc         (pc),
        .halted     (halted)
    );

    // Stand-in decoder: opcode in the top five bits, immediate in the low sixteen.
    assign opcode    = ir[32:28];
    assign immediate = ir[15:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] ir;
        int          cycles;
        int          rf_cnt;
        int          wb_sel;
        int          dmem_cnt;
        int          dmem_we;
        int          alu_op;
        logic [15:0] pc;
        logic        flag_z;
        int          halted;
    } exp_t;

    exp_t        sb_q[$];
    int          n_total = 0;
    int          n_bad   = 0;
    logic [15:0] m_pc    = 16'd0;
    logic        m_flag  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one instruction; also advances the model pc/flag.
    function automatic exp_t model(input logic [32:0] instr, input int fw, input int mw, input logic az);
        exp_t        e;
        logic [4:0]  op;
        logic [15:0] imm;
        op  = instr[32:28];
        imm = instr[15:0];
        e.ir = instr; e.rf_cnt = 0; e.wb_sel = 0; e.dmem_cnt = 0; e.dmem_we = 0;
        e.alu_op = int'(op); e.halted = 0; e.cycles = 3 + fw;
        case (op)
            5'd1: begin e.cycles = 5 + fw + mw; e.rf_cnt = 1; e.wb_sel = 1; e.dmem_cnt = mw + 1; end
            5'd3: begin e.cycles = 4 + fw + mw; e.dmem_cnt = mw + 1; e.dmem_we = 1; end
            5'd2: begin e.cycles = 4 + fw; e.rf_cnt = 1; e.wb_sel = 2; end
            5'd4, 5'd5, 5'd6, 5'd7, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13: begin
                e.cycles = 4 + fw; e.rf_cnt = 1;
            end
            default: ;
        endcase
        if (op == 5'd31) e.halted = 1;
        else if (op == 5'd15 && az) m_pc = m_pc + 16'd1 + imm;
        else if (op == 5'd14 && !az) m_pc = m_pc + 16'd1 + imm;
        else m_pc = m_pc + 16'd1;
        if (op == 5'd8) m_flag = az;
        e.pc = m_pc;
        e.flag_z = m_flag;
        return e;
    endfunction

    // Called positioned in FETCH just after a falling edge; returns at the next FETCH (or HALT).
    task automatic run_instr(input logic [32:0] instr, input int fw, input int mw, input logic az);
        int          cycles, fetch_cnt, dmem_cnt, rf_cnt, wbs, dwe, aop;
        bit          done, left_fetch, stable;
        logic [15:0] pc_start;
        exp_t        e;
        sb_q.push_back(model(instr, fw, mw, az));
        cycles = 0; fetch_cnt = 0; dmem_cnt = 0; rf_cnt = 0; wbs = 0; dwe = 0; aop = 0;
        done = 0; left_fetch = 0; stable = 1;
        pc_start = pc;
        alu_zero = az;
        while (!done) begin
            if (halted) begin
                done = 1;
            end else if (imem_req && left_fetch) begin
                done = 1;
            end else begin
                if (imem_req) begin
                    fetch_cnt++;
                    if (imem_addr !== pc_start || pc !== pc_start) stable = 0;
                    imem_rdata = instr;
                    imem_ready = (fetch_cnt > fw);
                end else begin
                    imem_ready = 1'b0;
                    left_fetch = 1;
                end
                if (dmem_req) begin
                    dmem_cnt++;
                    dwe |= int'(dmem_we);
                    dmem_ready = (dmem_cnt > mw);
                end else begin
                    dmem_ready = 1'b0;
                end
                if (rf_we) begin
                    rf_cnt++;
                    wbs = int'(wb_sel);
                end
                aop |= int'(alu_op);
                cycles++;
                if (cycles > 100) begin
                    check_eq("timeout", 32'(cycles), 32'd0);
                    done = 1;
                end else begin
                    @(negedge clk); #1;
                end
            end
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        e = sb_q.pop_front();
        check_eq("ir",       32'(ir),        32'(e.ir));
        check_eq("cycles",   32'(cycles),    32'(e.cycles));
        check_eq("rf_we",    32'(rf_cnt),    32'(e.rf_cnt));
        check_eq("wb_sel",   32'(wbs),       32'(e.wb_sel));
        check_eq("dmem_cyc", 32'(dmem_cnt),  32'(e.dmem_cnt));
        check_eq("dmem_we",  32'(dwe),       32'(e.dmem_we));
        check_eq("alu_op",   32'(aop),       32'(e.alu_op));
        check_eq("pc",       32'(pc),        32'(e.pc));
        check_eq("flag_z",   32'(flag_z),    32'(e.flag_z));
        check_eq("halted",   32'(halted),    32'(e.halted));
        check_eq("addr_stb", 32'(stable),    32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_pc   = 16'd0;
        m_flag = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        int hcnt;
        reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0; alu_zero = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_imem_req", 32'(imem_req), 32'd0);
        check_eq("rst_dmem_req", 32'(dmem_req), 32'd0);
        check_eq("rst_dmem_we",  32'(dmem_we),  32'd0);
        check_eq("rst_rf_we",    32'(rf_we),    32'd0);
        check_eq("rst_halted",   32'(halted),   32'd0);
        check_eq("rst_alu_op",   32'(alu_op),   32'd0);
        check_eq("rst_wb_sel",   32'(wb_sel),   32'd0);
        check_eq("rst_pc",       32'(pc),       32'd0);
        check_eq("rst_ir",       32'(ir),       32'd0);
        check_eq("rst_flag_z",   32'(flag_z),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("first_req", 32'(imem_req), 32'd1);

        run_instr(33'h011000010, 0, 0, 1'b0);   // LR, zero wait
        run_instr(33'h052210000, 3, 0, 1'b0);   // ADD, fetch stalled
        run_instr(33'h020000005, 0, 0, 1'b0);   // LI
        run_instr(33'h080000000, 0, 0, 1'b0);   // CMP, not equal
        run_instr(33'h080000000, 0, 0, 1'b1);   // CMP, equal
        run_instr(33'h0E130FFFD, 0, 0, 1'b0);   // BNE taken at pc 5
        run_instr(33'h000000000, 0, 0, 1'b0);
        run_instr(33'h000000000, 0, 0, 1'b0);
        run_instr(33'h0E130FFFD, 0, 0, 1'b1);   // BNE not taken at pc 5
        run_instr(33'h030100030, 0, 2, 1'b0);   // SR with data wait
        run_instr(33'h011000010, 1, 1, 1'b0);   // LR with both waits
        run_instr(33'h140000000, 0, 0, 1'b0);   // undefined opcode 20
        run_instr(33'h070000000, 0, 0, 1'b0);   // SUB

        // Abort an outstanding store with reset.
        imem_rdata = 33'h030100030; imem_ready = 1'b1; dmem_ready = 1'b0;
        @(negedge clk); #1;
        imem_ready = 1'b0;
        repeat (3) begin @(negedge clk); #1; end
        check_eq("mem_dmem_req", 32'(dmem_req), 32'd1);
        check_eq("mem_dmem_we",  32'(dmem_we),  32'd1);
        reset = 1'b1;
        #1;
        check_eq("abort_dmem_req", 32'(dmem_req), 32'd0);
        check_eq("abort_rf_we",    32'(rf_we),    32'd0);
        @(negedge clk); #1;
        check_eq("abort_pc",     32'(pc),       32'd0);
        check_eq("abort_flag",   32'(flag_z),   32'd0);
        check_eq("abort_no_req", 32'(imem_req), 32'd0);
        reset  = 1'b0;
        m_pc   = 16'd0;
        m_flag = 1'b0;
        #1;
        check_eq("resume_req",  32'(imem_req),  32'd1);
        check_eq("resume_addr", 32'(imem_addr), 32'd0);

        run_instr(33'h0F000FFFD, 0, 0, 1'b1);   // BE wraps backward to 0xFFFE
        run_instr(33'h0F000FFFD, 0, 0, 1'b0);   // BE not taken
        run_instr(33'h000000000, 0, 0, 1'b0);   // pc wraps to 0
        run_instr(33'h0F000FFFD, 0, 0, 1'b1);   // BE from pc 0 again

        do_reset();
        run_instr(33'h1F0000000, 0, 0, 1'b0);   // HALT
        hcnt = 0;
        imem_ready = 1'b1;
        repeat (20) begin
            @(negedge clk); #1;
            if (imem_req) hcnt++;
        end
        imem_ready = 1'b0;
        check_eq("halt_no_req", 32'(hcnt),   32'd0);
        check_eq("halt_stays",  32'(halted), 32'd1);
        check_eq("halt_pc",     32'(pc),     32'(m_pc));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
